// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types and constants for the continuous monitoring system control port,
// including the commit sequence used by the configuration sequencer.
package continuous_monitoring_system_pkg;

  localparam int CMS_CTRL_ADDR_WIDTH = 5;
  localparam int CMS_CTRL_DATA_WIDTH = 32;

  typedef logic [CMS_CTRL_ADDR_WIDTH-1:0] ctrl_addr_t;

  localparam ctrl_addr_t CLK_COUNTER                                = 5'h01;
  localparam ctrl_addr_t LAST_WRITE_TIMESTAMP                       = 5'h02;
  localparam ctrl_addr_t WFI_STOPPED                                = 5'h03;
  localparam ctrl_addr_t MONITORED_ADDRESS_RANGE_LOWER_BOUND         = 5'h04;
  localparam ctrl_addr_t MONITORED_ADDRESS_RANGE_UPPER_BOUND         = 5'h05;
  localparam ctrl_addr_t TRIGGER_TRACE_START_ADDRESS                 = 5'h06;
  localparam ctrl_addr_t TRIGGER_TRACE_END_ADDRESS                   = 5'h07;
  localparam ctrl_addr_t MONITORED_ADDRESS_RANGE_LOWER_BOUND_ENABLED = 5'h08;
  localparam ctrl_addr_t MONITORED_ADDRESS_RANGE_UPPER_BOUND_ENABLED = 5'h09;
  localparam ctrl_addr_t TRIGGER_TRACE_START_ADDRESS_ENABLED         = 5'h0A;
  localparam ctrl_addr_t TRIGGER_TRACE_END_ADDRESS_ENABLED           = 5'h0B;

  localparam int CMS_SEQ_LEN       = 11;
  localparam int CMS_SEQ_IDX_WIDTH = $clog2(CMS_SEQ_LEN);

  // Element k is issued k-th; bounds/addresses precede their enables.
  localparam ctrl_addr_t [CMS_SEQ_LEN-1:0] CMS_SEQ_ORDER = {
    WFI_STOPPED,
    LAST_WRITE_TIMESTAMP,
    CLK_COUNTER,
    TRIGGER_TRACE_END_ADDRESS_ENABLED,
    TRIGGER_TRACE_START_ADDRESS_ENABLED,
    MONITORED_ADDRESS_RANGE_UPPER_BOUND_ENABLED,
    MONITORED_ADDRESS_RANGE_LOWER_BOUND_ENABLED,
    TRIGGER_TRACE_END_ADDRESS,
    TRIGGER_TRACE_START_ADDRESS,
    MONITORED_ADDRESS_RANGE_UPPER_BOUND,
    MONITORED_ADDRESS_RANGE_LOWER_BOUND
  };

  // Bit k set: shadow entry k resets to all-ones (upper bound, end address).
  localparam logic [CMS_SEQ_LEN-1:0] CMS_SHADOW_ONES = 11'b000_0000_1010;

  typedef enum logic [1:0] {
    IDLE,
    QUIESCE,
    WRITE,
    RESUME
  } cms_seq_state_t;

endpackage

// File: rtl/cms_shadow_regs.sv
// Shadow copy of the monitor configuration: host write decode, combinational
// readback by address, and an indexed read port for the commit sequence.
module cms_shadow_regs
  import continuous_monitoring_system_pkg::*;
#(
  parameter int DATA_WIDTH = CMS_CTRL_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  ctrl_addr_t                   waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  ctrl_addr_t                   raddr,
  output logic [DATA_WIDTH-1:0]        rdata,
  input  logic [CMS_SEQ_IDX_WIDTH-1:0] idx,
  output logic [DATA_WIDTH-1:0]        idx_data
);

  logic [DATA_WIDTH-1:0] bank [CMS_SEQ_LEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CMS_SEQ_LEN; k++) begin
        bank[k] <= {DATA_WIDTH{CMS_SHADOW_ONES[k]}};
      end
    end else begin
      // Addresses outside the sequence match no entry and are dropped.
      for (int k = 0; k < CMS_SEQ_LEN; k++) begin
        if (we && (waddr == CMS_SEQ_ORDER[k])) begin
          bank[k] <= wdata;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < CMS_SEQ_LEN; k++) begin
      if (raddr == CMS_SEQ_ORDER[k]) begin
        rdata = bank[k];
      end
    end
  end

  assign idx_data = bank[idx];

endmodule

// File: rtl/cms_config_sequencer.sv
// Commit sequencer for the monitor control port: quiesce capture, wait for the
// trace stream to drain (bounded), replay all shadow registers, then resume.
module cms_config_sequencer
  import continuous_monitoring_system_pkg::*;
#(
  parameter int CTRL_DATA_WIDTH = CMS_CTRL_DATA_WIDTH,
  parameter int QUIESCE_TIMEOUT = 1024,
  parameter int SEQ_LEN         = CMS_SEQ_LEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       host_we,
  input  ctrl_addr_t                 host_addr,
  input  logic [CTRL_DATA_WIDTH-1:0] host_wdata,
  input  ctrl_addr_t                 host_raddr,
  output logic [CTRL_DATA_WIDTH-1:0] host_rdata,
  input  logic                       host_enable,
  input  logic                       commit,
  input  logic                       stream_idle,
  output logic                       cms_en,
  output logic                       ctrl_write_enable,
  output ctrl_addr_t                 ctrl_addr,
  output logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
  output logic                       busy,
  output logic                       done,
  output logic                       commit_dropped,
  output logic                       timeout_flag
);

  localparam int WAIT_W = $clog2(QUIESCE_TIMEOUT + 1);
  localparam int IDX_W  = CMS_SEQ_IDX_WIDTH;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(QUIESCE_TIMEOUT);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SEQ_LEN - 1);

  cms_seq_state_t              state;
  logic [1:0]                  idle_cnt;
  logic [WAIT_W-1:0]           wait_cnt;
  logic [IDX_W-1:0]            idx;
  logic [CTRL_DATA_WIDTH-1:0]  seq_data;

  cms_shadow_regs #(
    .DATA_WIDTH(CTRL_DATA_WIDTH)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .we       (host_we),
    .waddr    (host_addr),
    .wdata    (host_wdata),
    .raddr    (host_raddr),
    .rdata    (host_rdata),
    .idx      (idx),
    .idx_data (seq_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      idle_cnt          <= '0;
      wait_cnt          <= '0;
      idx               <= '0;
      ctrl_write_enable <= 1'b0;
      cms_en            <= 1'b0;
      done              <= 1'b0;
      commit_dropped    <= 1'b0;
      timeout_flag      <= 1'b0;
    end else begin
      done           <= 1'b0;
      commit_dropped <= commit && (state != IDLE);
      unique case (state)
        IDLE: begin
          cms_en <= host_enable && !commit;
          if (commit) begin
            state        <= QUIESCE;
            idle_cnt     <= '0;
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
          end
        end
        QUIESCE: begin
          cms_en <= 1'b0;
          // A drained stream wins over a timeout landing in the same cycle.
          if (stream_idle && (idle_cnt == 2'd1)) begin
            state             <= WRITE;
            idx               <= '0;
            ctrl_write_enable <= 1'b1;
          end else if (wait_cnt == WAIT_LAST) begin
            state             <= WRITE;
            idx               <= '0;
            ctrl_write_enable <= 1'b1;
            timeout_flag      <= 1'b1;
          end else begin
            idle_cnt <= stream_idle ? idle_cnt + 2'd1 : 2'd0;
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WRITE: begin
          cms_en <= 1'b0;
          if (idx == IDX_LAST) begin
            state             <= RESUME;
            idx               <= '0;
            ctrl_write_enable <= 1'b0;
            done              <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RESUME: begin
          state  <= IDLE;
          cms_en <= host_enable;
        end
        default: begin
          state  <= IDLE;
          cms_en <= 1'b0;
        end
      endcase
    end
  end

  // Data is read from the shadow in the issuing cycle, so a same-cycle host
  // write to that entry lands in the shadow but not on the control port.
  assign ctrl_addr  = CMS_SEQ_ORDER[idx];
  assign ctrl_wdata = ctrl_write_enable ? seq_data : '0;
  assign busy       = (state != IDLE);

endmodule
